// File: rtl/blit_pkg.sv
// Shared types and helpers for the blit pixel writer: default widths, the
// queued write record and the inclusive signed clip test.
package blit_pkg;

  localparam int DEF_ADDR_WIDTH = 26;
  localparam int COLOR_W        = 8;
  localparam int COORD_W        = 16;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [1:0]                lane;
  } pixel_req_t;

  // An empty rectangle (x1 > x2 or y1 > y2) falls out naturally as a miss.
  function automatic logic clip_hit(
    input logic signed [COORD_W-1:0] x,
    input logic signed [COORD_W-1:0] y,
    input logic signed [COORD_W-1:0] x1,
    input logic signed [COORD_W-1:0] y1,
    input logic signed [COORD_W-1:0] x2,
    input logic signed [COORD_W-1:0] y2
  );
    return (x >= x1) && (x <= x2) && (y >= y1) && (y <= y2);
  endfunction

endpackage

// File: rtl/blit_mem_if.sv
// Single-byte write port between the pixel writer (master) and memory (slave).
interface blit_mem_if #(
  parameter int ADDR_WIDTH = blit_pkg::DEF_ADDR_WIDTH
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_byte_en;
  logic                  mem_ack;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_byte_en,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_byte_en,
    output mem_ack
  );
endinterface

// File: rtl/blit_wr_fifo.sv
// Generic synchronous FIFO; DEPTH must be a power of two so the pointers wrap
// for free. Head data is presented combinationally on rdata.
module blit_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/blit_pixel_writer.sv
// Line-draw back end: clips each stepper pixel, turns it into an 8bpp byte
// address, queues it and issues single-byte writes with upstream backpressure.
module blit_pixel_writer
  import blit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  input  logic signed [COORD_W-1:0] in_x,
  input  logic signed [COORD_W-1:0] in_y,
  input  logic [COLOR_W-1:0]        color,
  input  logic [ADDR_WIDTH-1:0]     dest_base,
  input  logic [15:0]               dest_stride,
  input  logic signed [COORD_W-1:0] clip_x1,
  input  logic signed [COORD_W-1:0] clip_y1,
  input  logic signed [COORD_W-1:0] clip_x2,
  input  logic signed [COORD_W-1:0] clip_y2,
  output logic                      stall,
  blit_mem_if.master                mem,
  output logic                      busy,
  output logic [15:0]               clip_count
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int PAW = DEF_ADDR_WIDTH;

  logic                  accept, hit;
  logic signed [31:0]    row_off, x_ext;
  logic [ADDR_WIDTH-1:0] addr_w;

  logic                  s1_valid, s1_drop;
  pixel_req_t            s1_req, head;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty, pop;

  // Room check counts the entry still in stage 1, so its push never overflows.
  assign stall  = fifo_full | (s1_valid & (fifo_count == CW'(FIFO_DEPTH - 1)));
  assign accept = in_valid & ~stall;
  assign hit    = clip_hit(in_x, in_y, clip_x1, clip_y1, clip_x2, clip_y2);

  // Signed row offset: y sign-extended, stride zero-extended, 32-bit product.
  assign row_off = $signed({{16{in_y[15]}}, in_y}) * $signed({16'b0, dest_stride});
  assign x_ext   = $signed({{16{in_x[15]}}, in_x});
  assign addr_w  = dest_base + ADDR_WIDTH'(row_off) + ADDR_WIDTH'(x_ext);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_drop    <= 1'b0;
      s1_req     <= '0;
      clip_count <= '0;
    end else begin
      s1_valid <= accept & hit;
      s1_drop  <= accept & ~hit;
      if (accept & hit) begin
        s1_req.addr <= PAW'(addr_w);
        s1_req.lane <= addr_w[1:0];
      end
      if (s1_drop) clip_count <= clip_count + 16'd1;
    end
  end

  blit_wr_fifo #(
    .WIDTH ($bits(pixel_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (s1_valid),
    .wdata   (s1_req),
    .pop     (pop),
    .rdata   (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop  = mem.mem_req & mem.mem_ack;
  assign busy = s1_valid | ~fifo_empty;

  // Port outputs are forced to zero while idle so reset leaves them all low.
  assign mem.mem_req     = ~fifo_empty;
  assign mem.mem_addr    = mem.mem_req ? ADDR_WIDTH'(head.addr) : '0;
  assign mem.mem_byte_en = mem.mem_req ? (4'b0001 << head.lane) : 4'b0000;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign mem.mem_wdata[8*g +: 8] = mem.mem_req ? color : 8'h00;
  end

endmodule
